regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (WB/writeReg/writeData) among NUM_REQ writeback sources
//  (e.g. ALU, load unit, mul/div). Round-robin grant, one write per cycle, valid/ready handshake.

---
 rtl/regfile_wb_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared constants, index type and bus-slice helper for the writeback arbiter
package regfile_wb_pkg;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         DEFAULT_DATA_W  = 32;
   localparam int         DEFAULT_ADDR_W  = 5;
   localparam int         DEFAULT_NUM_REQ = 3;

   // Widest slice and widest flattened bus the slice helper can take.
   localparam int SLICE_MAX = 64;
   localparam int BUS_MAX   = 512;

   typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] reqIdx_t;

   function automatic logic [SLICE_MAX-1:0] getSlice(input logic [BUS_MAX-1:0] bus,
                                                    input int unsigned idx,
                                                    input int unsigned width);
      logic [SLICE_MAX-1:0] mask;
      mask = (width >= SLICE_MAX) ? '1 : ((SLICE_MAX'(1) << width) - SLICE_MAX'(1));
      return SLICE_MAX'(bus >> (idx * width)) & mask;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - masked round-robin grant starting at ptr, wrapping upward
module rr_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grantIdx
);

   logic [NUM_REQ-1:0] upperMask;
   logic [NUM_REQ-1:0] maskedReq;

   // Requests at or above ptr take precedence; otherwise wrap to the lowest request.
   always_comb begin
      logic found;
      upperMask = '0;
      grant     = '0;
      grantIdx  = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upperMask[i] = (IDX_W'(i) >= ptr);
      end
      maskedReq = req & upperMask;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && maskedReq[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grantIdx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grantIdx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port
// Optional age-based override enabled by defining WBARB_AGE_EN.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int NUM_REQ  = DEFAULT_NUM_REQ,
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int MAX_WAIT = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      WB,
   output logic [ADDR_W-1:0]         writeReg,
   output logic [DATA_W-1:0]         writeData,
   output logic [NUM_REQ-1:0]        wb_stall
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_WAIT < 1 || DATA_W > SLICE_MAX) begin : gBadParam
      $error("regfile_wb_arbiter: unsupported parameter combination");
   end

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   rrIdx;
   logic [IDX_W-1:0]   selIdx;
   logic [NUM_REQ-1:0] rrGrant;
   logic [NUM_REQ-1:0] selGrant;
   logic               transfer;
   logic [ADDR_W-1:0]  selReg;
   logic [DATA_W-1:0]  selData;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uRrArbiter (
      .req      (req_valid),
      .ptr      (ptr),
      .grant    (rrGrant),
      .grantIdx (rrIdx)
   );

`ifdef WBARB_AGE_EN
   localparam int               AGE_W   = $clog2(MAX_WAIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   logic [AGE_W-1:0] age [NUM_REQ];

   // A requester that has waited MAX_WAIT cycles wins outright; lowest index breaks ties.
   always_comb begin
      logic             agedFound;
      logic [IDX_W-1:0] agedIdx;
      agedFound = 1'b0;
      agedIdx   = '0;
      selGrant  = rrGrant;
      selIdx    = rrIdx;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!agedFound && req_valid[i] && age[i] == AGE_MAX) begin
            agedFound = 1'b1;
            agedIdx   = IDX_W'(i);
         end
      end
      if (agedFound) begin
         selGrant          = '0;
         selGrant[agedIdx] = 1'b1;
         selIdx            = agedIdx;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst || !req_valid[i] || req_ready[i]) begin
            age[i] <= '0;
         end else if (age[i] != AGE_MAX) begin
            age[i] <= age[i] + AGE_W'(1);
         end
      end
   end
`else
   assign selGrant = rrGrant;
   assign selIdx   = rrIdx;
`endif

   assign req_ready = rst ? '0 : selGrant;
   assign transfer  = |(req_valid & req_ready);
   assign wb_stall  = req_valid & ~req_ready;

   assign selReg  = ADDR_W'(getSlice(BUS_MAX'(req_reg), 32'(selIdx), ADDR_W));
   assign selData = DATA_W'(getSlice(BUS_MAX'(req_data), 32'(selIdx), DATA_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (transfer) begin
         ptr <= (selIdx == IDX_W'(NUM_REQ - 1)) ? '0 : selIdx + IDX_W'(1);
      end
   end

   // Register-0 transfers are consumed but never raise the write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         WB        <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (transfer) begin
         WB        <= (selReg != ADDR_W'(REG_ZERO));
         writeReg  <= selReg;
         writeData <= selData;
      end else begin
         WB <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_reg;
   logic [N*DW-1:0] req_data;
   logic            WB;
   logic [AW-1:0]   writeReg;
   logic [DW-1:0]   writeData;
   logic [N-1:0]    wb_stall;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .NUM_REQ  (N),
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .MAX_WAIT (MW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .WB        (WB),
      .writeReg  (writeReg),
      .writeData (writeData),
      .wb_stall  (wb_stall)
   );

   typedef struct {
      logic          wb;
      logic          chk;
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } exp_t;

   exp_t expQ[$];
   exp_t mon;
   int   nVec  = 0;
   int   nFail = 0;

   bit            vld [N];
   logic [AW-1:0] rg  [N];
   logic [DW-1:0] dt  [N];

   int            mPtr;
   int            mAge [N];
   logic [AW-1:0] lastReg;
   logic [DW-1:0] lastData;
   bit            known;
   int            grantHist[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      nVec++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int modelGrant();
`ifdef WBARB_AGE_EN
      for (int i = 0; i < N; i++)
         if (vld[i] && mAge[i] == MW) return i;
`endif
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (mPtr + k) % N;
         if (vld[idx]) return idx;
      end
      return -1;
   endfunction

   // One clock cycle: drive, check the grant, queue the expected write, advance the model.
   task automatic step();
      int            g;
      int            actIdx;
      logic [N-1:0]  vVec;
      logic [N-1:0]  expReady;
      exp_t          e;
      for (int i = 0; i < N; i++) begin
         vVec[i]               = vld[i];
         req_reg[i*AW +: AW]   = rg[i];
         req_data[i*DW +: DW]  = dt[i];
      end
      req_valid = vVec;
      #1;
      g = rst ? -1 : modelGrant();
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(expReady));
      check("wb_stall", 64'(wb_stall), 64'(vVec & ~expReady));
      actIdx = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) actIdx = i;
      grantHist.push_back(actIdx);
      if (rst) begin
         e.wb = 1'b0; e.chk = 1'b1; e.r = '0; e.d = '0;
         mPtr = 0; known = 1'b1; lastReg = '0; lastData = '0;
         for (int i = 0; i < N; i++) mAge[i] = 0;
      end else begin
         if (g >= 0) begin
            if (rg[g] != 0) begin
               e.wb = 1'b1; e.chk = 1'b1; e.r = rg[g]; e.d = dt[g];
               lastReg = rg[g]; lastData = dt[g]; known = 1'b1;
            end else begin
               e.wb = 1'b0; e.chk = 1'b0; e.r = '0; e.d = '0;
               known = 1'b0;
            end
            mPtr = (g + 1) % N;
         end else begin
            e.wb = 1'b0; e.chk = known; e.r = lastReg; e.d = lastData;
         end
         for (int i = 0; i < N; i++) begin
            if (!vld[i] || i == g) mAge[i] = 0;
            else if (mAge[i] < MW) mAge[i] = mAge[i] + 1;
         end
         if (g >= 0) vld[g] = 1'b0;
      end
      expQ.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            check("WB", 64'(WB), 64'(mon.wb));
            if (mon.chk) begin
               check("writeReg", 64'(writeReg), 64'(mon.r));
               check("writeData", 64'(writeData), 64'(mon.d));
            end
         end
      end
   end

   task automatic setAll(input bit v);
      for (int i = 0; i < N; i++) begin
         vld[i] = v;
         rg[i]  = AW'($urandom_range(1, 31));
         dt[i]  = $urandom;
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_reg = '0; req_data = '0;
      mPtr = 0; known = 1'b1; lastReg = '0; lastData = '0;
      for (int i = 0; i < N; i++) mAge[i] = 0;

      // reset with every requester asserting
      setAll(1'b1);
      step();
      setAll(1'b1);
      step();
      rst = 1'b0;

      // fairness from pointer 0
      grantHist.delete();
      for (int k = 0; k < 6; k++) begin
         setAll(1'b1);
         step();
      end
      check("fair_count", 64'(grantHist.size()), 64'd6);
      for (int k = 0; k < 6 && k < grantHist.size(); k++)
         check("fair_order", 64'(grantHist[k]), 64'(k % 3));

      // single write, then idle
      setAll(1'b0);
      vld[0] = 1'b1; rg[0] = 5'd20; dt[0] = 32'd50;
      step();
      step();
      step();

      // register 0 absorbed; pointer must move to 2
      setAll(1'b0);
      vld[1] = 1'b1; rg[1] = 5'd0; dt[1] = 32'd99;
      step();
      grantHist.delete();
      setAll(1'b1);
      step();
      check("ptr_after_reg0", 64'(grantHist[0]), 64'd2);

      // reset while a grant is pending
      setAll(1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      grantHist.delete();
      setAll(1'b1);
      step();
      check("ptr_after_reset", 64'(grantHist[0]), 64'd0);

      // requester 2 held while 0 and 1 keep re-requesting
      setAll(1'b0);
      vld[2] = 1'b1; rg[2] = 5'd7; dt[2] = 32'hCAFE_0002;
      for (int k = 0; k < 5; k++) begin
         vld[0] = 1'b1; rg[0] = AW'($urandom_range(1, 31)); dt[0] = $urandom;
         vld[1] = 1'b1; rg[1] = AW'($urandom_range(1, 31)); dt[1] = $urandom;
         step();
      end

      // randomized traffic honouring hold-until-accepted
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!vld[i] && $urandom_range(0, 3) != 0) begin
               vld[i] = 1'b1;
               rg[i]  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
               dt[i]  = $urandom;
            end
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      setAll(1'b0);
      step();

      @(posedge clk);
      #2;
      check("queue_drained", 64'(expQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
